// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Define FAST_MUL_EN to replace the shift-add multiply with a single-cycle product.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [1:0]         state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic               q_neg_q, q_neg_d;
  logic               r_neg_q, r_neg_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               div_zero_q, div_zero_d;

  logic               div0;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     rem_sh;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem_sub;

  // A divide by zero runs as unsigned so the raw dividend lands in HI
  // and the quotient naturally comes out all ones.
  assign div0  = op[1] && (src_b == '0);
  assign a_neg = ~op[0] & src_a[WIDTH-1] & ~div0;
  assign b_neg = ~op[0] & src_b[WIDTH-1] & ~div0;
  assign a_mag = a_neg ? -src_a : src_a;
  assign b_mag = b_neg ? -src_b : src_b;

  // Restoring step: the partial remainder shifted left by one is W+1 bits.
  assign rem_sh      = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_ge      = rem_sh >= {1'b0, opnd_q};
  assign div_rem_sub = rem_sh[WIDTH-1:0] - opnd_q;

`ifdef FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod;
  assign fast_prod = {{WIDTH{1'b0}}, opnd_q} * {{WIDTH{1'b0}}, acc_q[WIDTH-1:0]};
`else
  logic [WIDTH:0] mul_sum;
  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                 + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
`endif

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    opnd_d     = opnd_q;
    cnt_d      = cnt_q;
    is_div_d   = is_div_q;
    q_neg_d    = q_neg_q;
    r_neg_d    = r_neg_q;
    dz_d       = dz_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    div_zero_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          // Multiplier / dividend sits in the low half of the accumulator.
          acc_d    = {{WIDTH{1'b0}}, op[1] ? a_mag : b_mag};
          opnd_d   = op[1] ? b_mag : a_mag;
          cnt_d    = '0;
          is_div_d = op[1];
          q_neg_d  = a_neg ^ b_neg;
          r_neg_d  = a_neg;
          dz_d     = div0;
          state_d  = op[1] ? S_DIV : S_MUL;
        end else begin
          if (wr_hi) hi_d = wr_data;
          if (wr_lo) lo_d = wr_data;
        end
      end
      S_MUL: begin
`ifdef FAST_MUL_EN
        acc_d   = fast_prod;
        state_d = S_FIX;
`else
        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) state_d = S_FIX;
`endif
      end
      S_DIV: begin
        acc_d = {div_ge ? div_rem_sub : rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], div_ge};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) state_d = S_FIX;
      end
      S_FIX: begin
        if (is_div_q) begin
          lo_d = q_neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
          hi_d = r_neg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        end else begin
          {hi_d, lo_d} = q_neg_q ? -acc_q : acc_q;
        end
        done_d     = 1'b1;
        div_zero_d = dz_q;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= S_IDLE;
      acc_q      <= '0;
      opnd_q     <= '0;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      q_neg_q    <= 1'b0;
      r_neg_q    <= 1'b0;
      dz_q       <= 1'b0;
      hi_q       <= '0;
      lo_q       <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      opnd_q     <= opnd_d;
      cnt_q      <= cnt_d;
      is_div_q   <= is_div_d;
      q_neg_q    <= q_neg_d;
      r_neg_q    <= r_neg_d;
      dz_q       <= dz_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative integer multiply/divide unit with architectural HI/LO registers for the EX stage; handles MULT, MULTU, DIV and DIVU.
- Width is parametrised; operations take multiple cycles under a start/busy/done handshake.
- Supports signed and unsigned modes, divide-by-zero and signed-overflow handling, and direct HI/LO writes (MTHI/MTLO).
- The EX stage stalls on busy and reads hi/lo for MFHI/MFLO.

Parameters:
- WIDTH, 32, operand and HI/LO width; must be even, >= 8.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  synchronous active-low reset.
- start  in  1  launch operation; sampled only in IDLE.
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- src_a  in  WIDTH  rs operand: multiplicand or dividend.
- src_b  in  WIDTH  rt operand: multiplier or divisor.
- wr_hi  in  1  write wr_data to HI (MTHI).
- wr_lo  in  1  write wr_data to LO (MTLO).
- wr_data  in  WIDTH  data for wr_hi/wr_lo.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse; HI/LO hold the new result in this cycle.
- div_zero  out  1  pulses with done when a DIV/DIVU had src_b==0.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (RST==0 at an edge): state IDLE; hi=0, lo=0, busy=0, done=0, div_zero=0. Reset mid-operation aborts it with no partial HI/LO update.
- States:
  - IDLE: start==1 latches operands and op. Signed ops take absolute values and record the result sign. Go to MUL or DIV; busy=1 from the next cycle.
  - MUL: radix-2 shift-add over WIDTH cycles, 2*WIDTH-bit accumulator.
  - DIV: restoring division over WIDTH cycles.
  - FIX: 1 cycle. Apply sign correction, write HI/LO, return to IDLE. busy=0 and done=1 in the following cycle.
- Latency: start sampled at edge t. busy=1 for cycles t+1 .. t+WIDTH+1. done=1 and new hi/lo visible in cycle t+WIDTH+2.
- Multiply results: {hi,lo} = full 2*WIDTH-bit product. Signed (MULT) uses two's-complement operands; unsigned (MULTU) uses raw operands.
- Divide results: lo = quotient (truncated toward zero), hi = remainder (sign follows dividend).
- Divide by zero: DIV or DIVU with src_b==0 still takes full latency. Result hi=src_a, lo=all ones, div_zero=1 with done.
- Signed overflow: DIV with src_a = most-negative value and src_b = all ones gives lo = most-negative value, hi=0. No flag.
- start while busy: ignored, no queueing.
- wr_hi/wr_lo while busy: ignored.
- wr_hi/wr_lo in IDLE: register updated at the next edge. Both may be asserted together.
- start and wr_hi/wr_lo in the same IDLE cycle: start wins, the write is dropped.
- done and div_zero are single-cycle pulses, never held.
- Back-to-back: start may be asserted in the done cycle. It is accepted then, because the state is IDLE.

Optional Feature:
- FAST_MUL_EN defined: MULT/MULTU compute the full product in a single MUL cycle using a combinational multiplier, then FIX. done appears at t+3. DIV is unchanged.
- FAST_MUL_EN undefined: iterative multiply with latency WIDTH+2, as above.

Test Plan:
- MULT, src_a=0xFFFFFFFD (-3), src_b=5 -> at t+34: hi=0xFFFFFFFF, lo=0xFFFFFFF1, done=1 for one cycle, busy high t+1..t+33.
- MULTU, 0xFFFFFFFF * 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. With FAST_MUL_EN defined, same values at t+3.
- DIV, src_a=0xFFFFFFF9 (-7), src_b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 -> lo=14, hi=2.
- DIVU, src_a=7, src_b=0 -> hi=7, lo=0xFFFFFFFF, div_zero=1 with done. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0.
- Handshake: start again at t+5 -> ignored, result at t+34 unchanged. wr_hi=1, wr_data=0x1234 while busy -> ignored. Same write in IDLE -> hi=0x1234 next cycle. start+wr_lo same cycle -> lo shows only the op result.
- Reset: RST=0 at t+10 of a DIV -> hi=lo=0, busy=0, no done. A new start after release completes normally.
